// File: rtl/dfe_pkg.sv
// Shared definitions for the PDM front end: sequencer state encoding,
// sample width and counter widths.
package dfe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAKE   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    localparam int SAMPLE_W   = 8;
    localparam int WAKE_CNT_W = 16;
    localparam int WARM_CNT_W = 8;
    localparam int DIV_W      = 8;

endpackage

// File: rtl/pdm_sequencer_if.sv
// Bus between the PDM sequencer and the decimation filter.
interface pdm_sequencer_if;

    logic                                filt_en;
    logic                                filt_data;
    logic                                filt_valid;
    logic signed [dfe_pkg::SAMPLE_W-1:0] filt_out_data;
    logic                                filt_out_valid;

    modport master (
        output filt_en, filt_data, filt_valid,
        input  filt_out_data, filt_out_valid
    );

    modport slave (
        input  filt_en, filt_data, filt_valid,
        output filt_out_data, filt_out_valid
    );

endinterface

// File: rtl/pdm_clkgen.sv
// PDM clock divider; fall_o flags that pdm_clk_o drops on the coming edge.
module pdm_clkgen
    import dfe_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] half_i,
    output logic             pdm_clk_o,
    output logic             fall_o
);

    logic [DIV_W-1:0] cnt_q;
    logic             pdm_clk_q;
    logic             wrap;

    assign wrap      = run_i && (cnt_q == half_i - DIV_W'(1));
    assign fall_o    = wrap && pdm_clk_q;
    assign pdm_clk_o = pdm_clk_q;

    // Dropping run restarts the phase so the first rise is a full half-period away.
    always_ff @(posedge clk_i) begin
        if (rst_i || !run_i) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else if (wrap) begin
            cnt_q     <= '0;
            pdm_clk_q <= ~pdm_clk_q;
        end else begin
            cnt_q     <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pdm_sequencer.sv
// Power-up sequencer for a PDM microphone: wake clocking, filter warm-up,
// then gated pass-through of decimated samples.
module pdm_sequencer
    import dfe_pkg::*;
#(
    parameter int unsigned PDM_DIV_HALF   = 2,
    parameter int unsigned WAKE_PERIODS   = 16,
    parameter int unsigned WARMUP_SAMPLES = 4
)(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic                       pdm_data_i,
    output logic                       pdm_clk_o,
    output logic signed [SAMPLE_W-1:0] data_o,
    output logic                       valid_o,
    output logic                       busy_o,
    pdm_sequencer_if.master            filt
);

    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_PERIODS - 1);
    localparam logic [WARM_CNT_W-1:0] WARM_LAST =
        WARM_CNT_W'((WARMUP_SAMPLES == 0) ? 0 : WARMUP_SAMPLES - 1);

    state_e                      state_q;
    logic [WAKE_CNT_W-1:0]       wake_cnt_q;
    logic [WARM_CNT_W-1:0]       warm_cnt_q;
    logic                        filt_data_q;
    logic                        filt_valid_q;
    logic signed [SAMPLE_W-1:0]  data_q;
    logic                        valid_q;
    logic                        pdm_fall;
    logic                        clk_run;

    // A pending stop silences the clock on the same edge the FSM returns to IDLE.
    assign clk_run = (state_q != ST_IDLE) && !stop_i;

    pdm_clkgen u_clkgen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .run_i     (clk_run),
        .half_i    (DIV_W'(PDM_DIV_HALF)),
        .pdm_clk_o (pdm_clk_o),
        .fall_o    (pdm_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || stop_i) begin
            state_q      <= ST_IDLE;
            wake_cnt_q   <= '0;
            warm_cnt_q   <= '0;
            filt_data_q  <= 1'b0;
            filt_valid_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            filt_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            if (pdm_fall && (state_q == ST_WARMUP || state_q == ST_RUN)) begin
                filt_data_q  <= pdm_data_i;
                filt_valid_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    wake_cnt_q <= '0;
                    warm_cnt_q <= '0;
                    if (start_i) begin
                        state_q <= ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (pdm_fall) begin
                        if (wake_cnt_q == WAKE_LAST) begin
                            state_q <= ST_WARMUP;
                        end else begin
                            wake_cnt_q <= wake_cnt_q + WAKE_CNT_W'(1);
                        end
                    end
                end
                ST_WARMUP: begin
                    if (WARMUP_SAMPLES == 0) begin
                        state_q <= ST_RUN;
                    end else if (filt.filt_out_valid) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_q <= ST_RUN;
                        end else begin
                            warm_cnt_q <= warm_cnt_q + WARM_CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    valid_q <= filt.filt_out_valid;
                    if (filt.filt_out_valid) begin
                        data_q <= filt.filt_out_data;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign filt.filt_en    = (state_q == ST_WARMUP) || (state_q == ST_RUN);
    assign filt.filt_data  = filt_data_q;
    assign filt.filt_valid = filt_valid_q;
    assign data_o          = data_q;
    assign valid_o         = valid_q;

endmodule

// File: tb/tb_pdm_sequencer.sv
// Randomised scenario bench for pdm_sequencer: timing expectations come from
// period arithmetic, sample gating from strobe ordinals.
module tb_pdm_sequencer;

    localparam int HALF  = 2;
    localparam int WAKE  = 16;
    localparam int WARM  = 4;
    localparam int HALF2 = 1;
    localparam int WAKE2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, stop, pdmData;
    logic              pdmClk, validOut, busy;
    logic signed [7:0] dataOut;
    logic              start2, stop2;
    logic              pdmClk2, valid2, busy2;
    logic signed [7:0] data2;

    int nCompared   = 0;
    int nMismatched = 0;

    pdm_sequencer_if fif ();
    pdm_sequencer_if fif2 ();

    pdm_sequencer #(.PDM_DIV_HALF(HALF), .WAKE_PERIODS(WAKE), .WARMUP_SAMPLES(WARM)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .pdm_data_i(pdmData),
        .pdm_clk_o(pdmClk), .data_o(dataOut), .valid_o(validOut), .busy_o(busy), .filt(fif)
    );

    pdm_sequencer #(.PDM_DIV_HALF(HALF2), .WAKE_PERIODS(WAKE2), .WARMUP_SAMPLES(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .stop_i(stop2), .pdm_data_i(pdmData),
        .pdm_clk_o(pdmClk2), .data_o(data2), .valid_o(valid2), .busy_o(busy2), .filt(fif2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; pdmData = 1'b1;
        start2 = 1'b1; stop2 = 1'b0;
        fif.filt_out_valid = 1'b1; fif.filt_out_data = 8'sh55;
        fif2.filt_out_valid = 1'b1; fif2.filt_out_data = 8'sh2a;
        tick(); tick();
        nCompared++;
        if ({pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_dut got %b want 0",
                     {pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut});
        end
        nCompared++;
        if ({pdmClk2, fif2.filt_en, fif2.filt_data, fif2.filt_valid, valid2, busy2, data2} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_dut2 got %b want 0",
                     {pdmClk2, fif2.filt_en, fif2.filt_data, fif2.filt_valid, valid2, busy2, data2});
        end
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        fif.filt_out_valid = 1'b0; fif2.filt_out_valid = 1'b0;
        tick();
    endtask

    // Start, then watch 100 cycles: clock phase, wake length, capture strobes.
    task automatic test_wake_timing();
        logic expData = 1'b0;
        logic pd, expClk, expEn, expFv;
        start = 1'b1;
        tick();
        start = 1'b0;
        nCompared++;
        if (busy !== 1'b1 || pdmClk !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL start_entry got busy=%b clk=%b want busy=1 clk=0", busy, pdmClk);
        end
        for (int k = 1; k <= 100; k++) begin
            pd = 1'($urandom);
            pdmData = pd;
            start = ($urandom_range(0, 7) == 0);
            tick();
            expClk = (((k / HALF) % 2) == 1);
            expEn  = (k >= WAKE * 2 * HALF);
            expFv  = ((k % (2 * HALF)) == 0) && ((k - 1) >= WAKE * 2 * HALF);
            if (expFv) expData = pd;
            nCompared++;
            if (pdmClk !== expClk) begin
                nMismatched++;
                $display("[TB] FAIL pdm_clk k=%0d got %b want %b", k, pdmClk, expClk);
            end
            nCompared++;
            if (fif.filt_en !== expEn) begin
                nMismatched++;
                $display("[TB] FAIL filt_en k=%0d got %b want %b", k, fif.filt_en, expEn);
            end
            nCompared++;
            if (fif.filt_valid !== expFv) begin
                nMismatched++;
                $display("[TB] FAIL filt_valid k=%0d got %b want %b", k, fif.filt_valid, expFv);
            end
            nCompared++;
            if (fif.filt_data !== expData) begin
                nMismatched++;
                $display("[TB] FAIL filt_data k=%0d got %b want %b", k, fif.filt_data, expData);
            end
            nCompared++;
            if (busy !== 1'b1 || validOut !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL busy_valid k=%0d got %b%b want 10", k, busy, validOut);
            end
        end
        start = 1'b0;
    endtask

    // Seven filter strobes with random gaps: first WARM are swallowed.
    task automatic test_warmup_run();
        logic signed [7:0] expD = '0;
        logic signed [7:0] v;
        logic expV;
        for (int i = 0; i < 7; i++) begin
            repeat ($urandom_range(1, 3)) begin
                fif.filt_out_valid = 1'b0;
                tick();
                nCompared++;
                if (validOut !== 1'b0 || dataOut !== expD) begin
                    nMismatched++;
                    $display("[TB] FAIL gap_hold i=%0d got v=%b d=%0d want v=0 d=%0d", i, validOut, dataOut, expD);
                end
            end
            v = 8'($urandom);
            fif.filt_out_valid = 1'b1;
            fif.filt_out_data  = v;
            tick();
            fif.filt_out_valid = 1'b0;
            expV = (i >= WARM);
            if (expV) expD = v;
            nCompared++;
            if (validOut !== expV || dataOut !== expD) begin
                nMismatched++;
                $display("[TB] FAIL sample i=%0d got v=%b d=%0d want v=%b d=%0d", i, validOut, dataOut, expV, expD);
            end
        end
    endtask

    task automatic test_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        nCompared++;
        if ({pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL stop_run got %b want 0",
                     {pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut});
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (WAKE * 2 * HALF + 2) tick();
        repeat (2) begin
            fif.filt_out_valid = 1'b1;
            tick();
            fif.filt_out_valid = 1'b0;
            tick();
        end
        nCompared++;
        if (fif.filt_en !== 1'b1 || validOut !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL warmup_reached got en=%b v=%b want en=1 v=0", fif.filt_en, validOut);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        nCompared++;
        if ({pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL stop_warmup got %b want 0",
                     {pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut});
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick(); tick();
        nCompared++;
        if (busy !== 1'b0 || pdmClk !== 1'b0 || fif.filt_en !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL start_stop_idle got busy=%b clk=%b en=%b want 000", busy, pdmClk, fif.filt_en);
        end
    endtask

    task automatic test_reset_mid_run();
        fif.filt_out_valid = 1'b1;
        fif.filt_out_data  = 8'sh7b;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        fif.filt_out_valid = 1'b0;
        nCompared++;
        if ({pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_run got %b want 0",
                     {pdmClk, fif.filt_en, fif.filt_data, fif.filt_valid, validOut, busy, dataOut});
        end
        rst = 1'b0;
        test_wake_timing();
    endtask

    // Zero warm-up, divide-by-one: first strobe after filt_en passes straight out.
    task automatic test_fast_config();
        logic pd, expData, expClk, expEn, expFv, expV;
        logic signed [7:0] v;
        expData = 1'b0;
        v = 8'($urandom);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            pd = 1'($urandom);
            pdmData = pd;
            fif2.filt_out_valid = (k == 8);
            fif2.filt_out_data  = v;
            tick();
            fif2.filt_out_valid = 1'b0;
            expClk = (((k / HALF2) % 2) == 1);
            expEn  = (k >= WAKE2 * 2 * HALF2);
            expFv  = ((k % (2 * HALF2)) == 0) && ((k - 1) >= WAKE2 * 2 * HALF2);
            expV   = (k == 8);
            if (expFv) expData = pd;
            nCompared++;
            if (pdmClk2 !== expClk || fif2.filt_en !== expEn) begin
                nMismatched++;
                $display("[TB] FAIL fast_clk_en k=%0d got %b%b want %b%b", k, pdmClk2, fif2.filt_en, expClk, expEn);
            end
            nCompared++;
            if (fif2.filt_valid !== expFv || fif2.filt_data !== expData) begin
                nMismatched++;
                $display("[TB] FAIL fast_capture k=%0d got %b%b want %b%b", k, fif2.filt_valid, fif2.filt_data, expFv, expData);
            end
            nCompared++;
            if (valid2 !== expV || (k >= 8 && data2 !== v)) begin
                nMismatched++;
                $display("[TB] FAIL fast_sample k=%0d got v=%b d=%0d want v=%b d=%0d", k, valid2, data2, expV, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wake_timing();
        test_warmup_run();
        test_stop();
        test_wake_timing();
        test_warmup_run();
        test_reset_mid_run();
        test_warmup_run();
        test_fast_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
